// File: rtl/key_event_decoder.sv
// key_event_decoder
// Turns the debounced button level into single-cycle key events: press,
// release, long-press, auto-repeat and double-click, plus a wrapping press
// counter.
//
// Build option:
//   KEY_REPEAT_EN  defined   -> auto-repeat pulses while held past long-press
//                  undefined -> repeat_pulse tied low, LONG timer frozen
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   pb_in         debounced button level (synchronous to clk)
//   press_pulse   one-cycle pulse per press
//   release_pulse one-cycle pulse per release
//   long_pulse    one-cycle pulse when a hold reaches LONG_CYCLES
//   repeat_pulse  periodic pulse while held past the long-press point
//   dclick_pulse  coincident with press_pulse on the second press of a double-click
//   held          registered pressed level
//   press_count   wrapping count of press_pulse events
module key_event_decoder #(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned LONG_CYCLES   = 16,
  parameter int unsigned REPEAT_CYCLES = 4,
  parameter int unsigned DCLICK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       dclick_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  localparam int unsigned TW = 16;
  localparam int unsigned CW = 8;

  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_CYCLES - 1);

`ifdef KEY_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_LONG    = 2'd2;
  localparam logic [1:0] S_WAIT2   = 2'd3;

  logic          pressed_now;
  logic          pressed_q;
  logic          rise;
  logic          fall;
  logic          repeat_hit;

  logic [1:0]    state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic          dc_flag, dc_flag_d;
  logic [CW-1:0] count_d;
  logic          press_d, release_d, long_d, repeat_d, dclick_d;

  assign pressed_now = pb_in ^ ACTIVE_LOW;
  assign rise        = pressed_now & ~pressed_q;
  assign fall        = ~pressed_now & pressed_q;
  // Constant-folds to 0 when auto-repeat is compiled out.
  assign repeat_hit  = REPEAT_EN && (timer == REPEAT_LAST);
  assign held        = pressed_q;

  // Level register keeps tracking through reset so a button held across
  // reset is already "pressed" afterwards and produces no press event.
  always_ff @(posedge clk) begin
    pressed_q <= pressed_now;
  end

  // State, timer and registered event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      timer         <= '0;
      dc_flag       <= 1'b0;
      press_count   <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      dclick_pulse  <= 1'b0;
    end else begin
      state         <= state_d;
      timer         <= timer_d;
      dc_flag       <= dc_flag_d;
      press_count   <= count_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
      dclick_pulse  <= dclick_d;
    end
  end

  // Next-state and next-output logic; edges take priority over timer expiry.
  always_comb begin
    state_d   = state;
    timer_d   = timer + TW'(1);
    dc_flag_d = dc_flag;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    dclick_d  = 1'b0;

    case (state)
      S_IDLE: begin
        timer_d = '0;
        if (rise) begin
          press_d = 1'b1;
          state_d = S_PRESSED;
        end else if (fall) begin
          // Only reachable when the button was held through reset.
          release_d = 1'b1;
        end
      end

      S_PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = dc_flag ? S_IDLE : S_WAIT2;
          dc_flag_d = 1'b0;
          timer_d   = '0;
        end else if (timer == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = S_LONG;
          timer_d = '0;
        end
      end

      S_LONG: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = S_IDLE;
          dc_flag_d = 1'b0;
          timer_d   = '0;
        end else if (repeat_hit) begin
          repeat_d = 1'b1;
          timer_d  = '0;
        end else if (!REPEAT_EN) begin
          timer_d = timer;
        end
      end

      S_WAIT2: begin
        if (rise) begin
          press_d   = 1'b1;
          dclick_d  = 1'b1;
          dc_flag_d = 1'b1;
          state_d   = S_PRESSED;
          timer_d   = '0;
        end else if (timer == DCLICK_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    count_d = press_d ? press_count + CW'(1) : press_count;
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder with default parameters.
// Expected pulse events (cycle, pulse vector, press_count) are queued by the
// stimulus; a negedge monitor pops one entry whenever any pulse is high.
module tb_key_event_decoder;

  typedef struct {
    int         cyc;
    logic [4:0] v;    // {press, release, long, repeat, dclick}
    logic [7:0] cnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pb_in = 1'b1;
  logic       press_pulse, release_pulse, long_pulse, repeat_pulse, dclick_pulse;
  logic       held;
  logic [7:0] press_count;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_cnt = 8'd0;
  ev_t        q[$];
  int         t0;

  key_event_decoder dut (
    .clk(clk), .rst(rst), .pb_in(pb_in),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse),
    .dclick_pulse(dclick_pulse), .held(held), .press_count(press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Queue one expected event; press events advance the expected counter.
  task automatic exp_ev(input int c, input bit p, input bit r, input bit l,
                        input bit rp, input bit d);
    ev_t e;
    if (p) exp_cnt = exp_cnt + 8'd1;
    e.cyc = c;
    e.v   = {p, r, l, rp, d};
    e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Hold the button pressed (1) or released (0) for n sampling edges.
  task automatic drive(input bit pressed, input int n);
    pb_in = ~pressed;
    repeat (n) sync();
  endtask

  // Monitor: every visible pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [4:0] v;
    ev_t e;
    v = {press_pulse, release_pulse, long_pulse, repeat_pulse, dclick_pulse};
    if (v != 5'b0) begin
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_event: got pulses %b count %0d at cycle %0d, expected none",
                 v, press_count, cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc == cyc && e.v == v && e.cnt == press_count) n_pass++;
        else $display("FAIL event: got cycle %0d pulses %b count %0d, expected cycle %0d pulses %b count %0d",
                      cyc, v, press_count, e.cyc, e.v, e.cnt);
      end
    end
  end

  initial begin
    // Reset with button released.
    repeat (3) sync();
    chk("reset_pulses", int'({press_pulse, release_pulse, long_pulse, repeat_pulse, dclick_pulse}), 0);
    chk("reset_count", int'(press_count), 0);
    chk("reset_held", int'(held), 0);
    rst = 1'b0;
    repeat (2) sync();

    // Short press of 5 cycles; WAIT2 times out afterwards.
    t0 = cyc;
    exp_ev(t0 + 1, 1, 0, 0, 0, 0);
    exp_ev(t0 + 6, 0, 1, 0, 0, 0);
    drive(1, 5);
    drive(0, 12);
    chk("count_after_short", int'(press_count), 1);

    // 30-cycle hold: long at +16, repeats every 4; later press is not a dclick.
    t0 = cyc;
    exp_ev(t0 + 1, 1, 0, 0, 0, 0);
    exp_ev(t0 + 17, 0, 0, 1, 0, 0);
`ifdef KEY_REPEAT_EN
    exp_ev(t0 + 21, 0, 0, 0, 1, 0);
    exp_ev(t0 + 25, 0, 0, 0, 1, 0);
    exp_ev(t0 + 29, 0, 0, 0, 1, 0);
`endif
    exp_ev(t0 + 31, 0, 1, 0, 0, 0);
    exp_ev(t0 + 34, 1, 0, 0, 0, 0);
    exp_ev(t0 + 36, 0, 1, 0, 0, 0);
    drive(1, 30);
    drive(0, 3);
    drive(1, 2);
    drive(0, 12);

    // Double-click, then a third press that must not be a dclick.
    t0 = cyc;
    exp_ev(t0 + 1, 1, 0, 0, 0, 0);
    exp_ev(t0 + 4, 0, 1, 0, 0, 0);
    exp_ev(t0 + 8, 1, 0, 0, 0, 1);
    exp_ev(t0 + 11, 0, 1, 0, 0, 0);
    exp_ev(t0 + 14, 1, 0, 0, 0, 0);
    exp_ev(t0 + 16, 0, 1, 0, 0, 0);
    drive(1, 3);
    drive(0, 4);
    drive(1, 3);
    drive(0, 3);
    drive(1, 2);
    drive(0, 12);
    chk("count_after_dclick", int'(press_count), 6);

    // Window edge: k=8 gives dclick (rise beats timeout).
    t0 = cyc;
    exp_ev(t0 + 1, 1, 0, 0, 0, 0);
    exp_ev(t0 + 3, 0, 1, 0, 0, 0);
    exp_ev(t0 + 11, 1, 0, 0, 0, 1);
    exp_ev(t0 + 13, 0, 1, 0, 0, 0);
    drive(1, 2);
    drive(0, 8);
    drive(1, 2);
    drive(0, 12);

    // Window edge: k=9 is too late.
    t0 = cyc;
    exp_ev(t0 + 1, 1, 0, 0, 0, 0);
    exp_ev(t0 + 3, 0, 1, 0, 0, 0);
    exp_ev(t0 + 12, 1, 0, 0, 0, 0);
    exp_ev(t0 + 14, 0, 1, 0, 0, 0);
    drive(1, 2);
    drive(0, 9);
    drive(1, 2);
    drive(0, 12);

    // Release on the long-press edge: release wins, no long.
    t0 = cyc;
    exp_ev(t0 + 1, 1, 0, 0, 0, 0);
    exp_ev(t0 + 17, 0, 1, 0, 0, 0);
    drive(1, 16);
    drive(0, 12);

    // One cycle longer: long fires; a long press never arms dclick.
    t0 = cyc;
    exp_ev(t0 + 1, 1, 0, 0, 0, 0);
    exp_ev(t0 + 17, 0, 0, 1, 0, 0);
    exp_ev(t0 + 18, 0, 1, 0, 0, 0);
    exp_ev(t0 + 22, 1, 0, 0, 0, 0);
    exp_ev(t0 + 24, 0, 1, 0, 0, 0);
    drive(1, 17);
    drive(0, 4);
    drive(1, 2);
    drive(0, 12);
    chk("count_after_long", int'(press_count), 13);

    // Button held through reset: no press, held=1; release still reported.
    rst = 1'b1;
    pb_in = 1'b0;
    exp_cnt = 8'd0;
    repeat (3) sync();
    rst = 1'b0;
    repeat (3) sync();
    chk("held_through_reset", int'(held), 1);
    chk("count_after_reset", int'(press_count), 0);
    t0 = cyc;
    exp_ev(t0 + 1, 0, 1, 0, 0, 0);
    exp_ev(t0 + 5, 1, 0, 0, 0, 0);
    exp_ev(t0 + 7, 0, 1, 0, 0, 0);
    drive(0, 4);
    drive(1, 2);
    drive(0, 12);

    // Reset mid-LONG drops the pending repeat and clears everything.
    t0 = cyc;
    exp_ev(t0 + 1, 1, 0, 0, 0, 0);
    exp_ev(t0 + 17, 0, 0, 1, 0, 0);
    drive(1, 20);
    rst = 1'b1;
    pb_in = 1'b1;
    exp_cnt = 8'd0;
    sync();
    chk("rst_long_pulses", int'({press_pulse, release_pulse, long_pulse, repeat_pulse, dclick_pulse}), 0);
    chk("rst_long_count", int'(press_count), 0);
    chk("rst_long_held", int'(held), 0);
    rst = 1'b0;
    drive(0, 3);

    // 256 one-cycle presses with one-cycle gaps: every second press is a dclick.
    t0 = cyc;
    for (int i = 0; i < 256; i++) begin
      exp_ev(t0 + 2 * i + 1, 1, 0, 0, 0, bit'(i % 2));
      exp_ev(t0 + 2 * i + 2, 0, 1, 0, 0, 0);
    end
    for (int i = 0; i < 256; i++) begin
      drive(1, 1);
      drive(0, 1);
    end
    drive(0, 12);
    chk("count_wrap", int'(press_count), 0);

    chk("pending_events", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
